// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder.
// The controller drives the selects and the decoder returns the one-hot digit strobe.
interface scan_decoder_if #(
    parameter int N = 3
);
    logic [1:0]      iEna;
    logic            iMode;
    logic [N-1:0]    iData;
    logic [N-1:0]    iLast;
    logic [2**N-1:0] oData;
    logic [N-1:0]    oSel;
    logic            oValid;

    modport master (
        output iEna, iMode, iData, iLast,
        input  oData, oSel, oValid
    );

    modport slave (
        input  iEna, iMode, iData, iLast,
        output oData, oSel, oValid
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder.
// Supports direct decode and a prescaled scan across positions 0..iLast.
module scan_decoder #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input logic           clk,
    input logic           rst,
    scan_decoder_if.slave bus
);
    localparam int W  = 2**N;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  IDLE     = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0] pre;
    logic [N-1:0]  next_sel;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
        logic [W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    // Out-of-range positions (after iLast shrinks) wrap instead of holding.
    always_comb begin
        next_sel = bus.oSel + N'(1);
        if (bus.oSel >= bus.iLast)
            next_sel = '0;
    end

    // An X on iEna makes the if-condition false, so it falls into the idle branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.oData  <= IDLE;
            bus.oSel   <= '0;
            bus.oValid <= 1'b0;
            pre        <= '0;
        end else if (bus.iEna == 2'b10) begin
            bus.oValid <= 1'b1;
            if (!bus.iMode) begin
                bus.oSel  <= bus.iData;
                bus.oData <= onehot(bus.iData);
                pre       <= '0;
            end else if (pre == PRE_LAST) begin
                pre       <= '0;
                bus.oSel  <= next_sel;
                bus.oData <= onehot(next_sel);
            end else begin
                pre       <= pre + PW'(1);
                bus.oData <= onehot(bus.oSel);
            end
        end else begin
            bus.oData  <= IDLE;
            bus.oValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed scoreboard bench for scan_decoder.
// Covers an active-high DIV=4 instance and an active-low DIV=1 instance.
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    scan_decoder_if #(.N(3)) bus_a ();
    scan_decoder_if #(.N(3)) bus_b ();

    scan_decoder #(.N(3), .DIV(4), .ACTIVE_LOW(0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    scan_decoder #(.N(3), .DIV(1), .ACTIVE_LOW(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic [2:0] s;
        logic       v;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'h01;
        return one << i;
    endfunction

    task automatic push_a(input string tag, input logic [7:0] d,
                          input logic [2:0] s, input logic v);
        exp_t e;
        e.tag = tag; e.d = d; e.s = s; e.v = v;
        qa.push_back(e);
    endtask

    task automatic push_b(input string tag, input logic [7:0] d,
                          input logic [2:0] s, input logic v);
        exp_t e;
        e.tag = tag; e.d = d; e.s = s; e.v = v;
        qb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        while (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            assert ({bus_a.oData, bus_a.oSel, bus_a.oValid} === {e.d, e.s, e.v})
            else begin
                errors++;
                $error("FAIL %s: observed d=%h s=%0d v=%b expected d=%h s=%0d v=%b",
                       e.tag, bus_a.oData, bus_a.oSel, bus_a.oValid, e.d, e.s, e.v);
            end
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            assert ({bus_b.oData, bus_b.oSel, bus_b.oValid} === {e.d, e.s, e.v})
            else begin
                errors++;
                $error("FAIL %s: observed d=%h s=%0d v=%b expected d=%h s=%0d v=%b",
                       e.tag, bus_b.oData, bus_b.oSel, bus_b.oValid, e.d, e.s, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        int sel;
        bus_a.iEna = 2'b00; bus_a.iMode = 1'b0;
        bus_a.iData = 3'd0; bus_a.iLast = 3'd0;
        bus_b.iEna = 2'b00; bus_b.iMode = 1'b1;
        bus_b.iData = 3'd0; bus_b.iLast = 3'd7;

        #1 rst = 1'b1;
        #3;
        push_a("reset_a", 8'h00, 3'd0, 1'b0);
        push_b("reset_b", 8'hFF, 3'd0, 1'b0);
        check_now();
        repeat (2) begin
            push_a("reset_hold_a", 8'h00, 3'd0, 1'b0);
            push_b("reset_hold_b", 8'hFF, 3'd0, 1'b0);
            tick();
        end
        rst = 1'b0;

        bus_a.iEna = 2'b10;
        bus_a.iMode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_a.iData = 3'(i);
            repeat (4) begin
                push_a("direct", oh(i), 3'(i), 1'b1);
                tick();
            end
        end

        #2 rst = 1'b1;
        #1;
        push_a("rst_async_a", 8'h00, 3'd0, 1'b0);
        push_b("rst_async_b", 8'hFF, 3'd0, 1'b0);
        check_now();
        bus_a.iEna = 2'bx1;
        #1 rst = 1'b0;
        repeat (3) begin
            push_a("ena_x1", 8'h00, 3'd0, 1'b0);
            tick();
        end
        bus_a.iEna = 2'b0x;
        repeat (3) begin
            push_a("ena_0x", 8'h00, 3'd0, 1'b0);
            tick();
        end

        bus_a.iEna = 2'b10;
        bus_a.iMode = 1'b1;
        bus_a.iLast = 3'd3;
        for (int k = 1; k <= 25; k++) begin
            sel = (k / 4) % 4;
            push_a("scan_wrap", oh(sel), 3'(sel), 1'b1);
            tick();
        end

        bus_a.iEna = 2'b00;
        repeat (10) begin
            push_a("disabled_hold", 8'h00, 3'd2, 1'b0);
            tick();
        end
        bus_a.iEna = 2'b10;
        for (int k = 26; k <= 32; k++) begin
            sel = (k / 4) % 4;
            push_a("scan_resume", oh(sel), 3'(sel), 1'b1);
            tick();
        end

        bus_a.iLast = 3'd7;
        for (int k = 33; k <= 57; k++) begin
            sel = k / 4 - 8;
            push_a("scan_last7", oh(sel), 3'(sel), 1'b1);
            tick();
        end
        bus_a.iLast = 3'd2;
        for (int k = 58; k <= 73; k++) begin
            sel = (k < 60) ? 6 : ((k - 60) / 4) % 3;
            push_a("last_shrink", oh(sel), 3'(sel), 1'b1);
            tick();
        end

        bus_a.iMode = 1'b0;
        bus_a.iData = 3'd5;
        push_a("scan_to_direct", 8'h20, 3'd5, 1'b1);
        tick();
        bus_a.iMode = 1'b1;
        bus_a.iLast = 3'd7;
        repeat (3) begin
            push_a("direct_to_scan", 8'h20, 3'd5, 1'b1);
            tick();
        end
        push_a("direct_to_scan_step", 8'h40, 3'd6, 1'b1);
        tick();

        bus_a.iEna = 2'b00;
        bus_b.iEna = 2'b10;
        for (int j = 1; j <= 10; j++) begin
            sel = j % 8;
            push_b("active_low_div1", ~oh(sel), 3'(sel), 1'b1);
            tick();
        end

        #2 rst = 1'b1;
        #1;
        push_b("rst_active_low", 8'hFF, 3'd0, 1'b0);
        check_now();
        #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
